// File: rtl/cp0.sv
// ---------------------------------------------------------------------------
// cp0 -- MIPS-style coprocessor 0 (SR, Cause, EPC, PRId).
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   reset        asynchronous active-low reset, clears SR/Cause/EPC
//   A1           mfc0 read select (combinational read)
//   A2, DIn, WE  mtc0 write select / data / enable (commit stage)
//   VPC, BDIn    PC and delay-slot flag of the committing instruction
//   ExcCodeIn    exception code of the committing instruction, 0 = none
//   HWInt        level-sensitive external interrupt lines
//   EXLClr       eret is committing
//   DOut         read data for A1
//   EPCOut       current EPC, the eret target
//   Req          take an exception/interrupt this cycle (combinational)
//   o_dbg_state  exception-level state (0 = NORMAL, 1 = HANDLER)
//
// Handshake note: there is no valid/ready pair here. WE and EXLClr are
// single-cycle strobes from the commit stage; Req is a combinational
// answer in the same cycle and the pipeline must flush when it is high.
// ---------------------------------------------------------------------------
module cp0 #(
  parameter logic [31:0] PRID = 32'h0000_2022
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic        Req,
  output logic        o_dbg_state
);

  // SR.EXL is the FSM state itself.
  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [5:0]  r_im;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_exl;
  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic        w_sr_wr;
  logic        w_epc_wr;
  logic [31:0] w_epc_capture;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  assign w_exl     = (r_state == ST_HANDLER);
  assign w_int_req = (|(HWInt & r_im)) & r_ie & ~w_exl;
  assign w_exc_req = (ExcCodeIn != 5'd0) & ~w_exl;
  assign w_req     = w_int_req | w_exc_req;

  // A write from an instruction that is being flushed must not land.
  assign w_sr_wr  = WE & ~w_req & (A2 == 5'd12);
  assign w_epc_wr = WE & ~w_req & (A2 == 5'd14);

  // A fault in a delay slot restarts at the branch, one word earlier.
  assign w_epc_capture = BDIn ? (VPC - 32'd4) : VPC;

  assign w_sr    = {16'h0, r_im, 8'h0, w_exl, r_ie};
  assign w_cause = {r_bd, 15'h0, r_ip, 3'h0, r_exccode, 2'h0};

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- FSM: next state ----
  // Priority: taking a trap, then eret (which also wins over the EXL bit
  // of a same-cycle mtc0 SR), then a plain SR write.
  always_comb begin
    w_state_nxt = r_state;
    if (w_req) begin
      w_state_nxt = ST_HANDLER;
    end else if (EXLClr) begin
      w_state_nxt = ST_NORMAL;
    end else if (w_sr_wr) begin
      w_state_nxt = DIn[1] ? ST_HANDLER : ST_NORMAL;
    end
  end

  // ---- SR / Cause / EPC datapath ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im      <= 6'd0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      // Pending-interrupt bits track the lines regardless of masking.
      r_ip <= HWInt;
      if (w_req) begin
        r_bd      <= BDIn;
        r_exccode <= w_int_req ? 5'd0 : ExcCodeIn;
        r_epc     <= w_epc_capture;
      end else begin
        if (w_sr_wr) begin
          r_im <= DIn[15:10];
          r_ie <= DIn[0];
        end
        if (w_epc_wr) begin
          r_epc <= DIn;
        end
      end
    end
  end

  // ---- read mux ----
  always_comb begin
    DOut = 32'd0;
    case (A1)
      5'd12:   DOut = w_sr;
      5'd13:   DOut = w_cause;
      5'd14:   DOut = r_epc;
      5'd15:   DOut = PRID;
      default: DOut = 32'd0;
    endcase
  end

  assign EPCOut      = r_epc;
  assign Req         = w_req;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cp0.sv
// ---------------------------------------------------------------------------
// tb_cp0 -- self-checking bench for cp0. A word-level reference model of
// SR/Cause/EPC is advanced once per clock from the architectural rules;
// directed scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_cp0;

  localparam logic [31:0] PRID    = 32'h0000_2022;
  localparam logic [31:0] SR_MASK = 32'h0000_FC03;

  // ---- clock / reset ----
  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic [4:0]  A1, A2, ExcCodeIn;
  logic [31:0] DIn, VPC;
  logic        WE, BDIn, EXLClr;
  logic [5:0]  HWInt;
  logic [31:0] DOut, EPCOut;
  logic        Req, o_dbg_state;

  cp0 #(.PRID(PRID)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .DOut(DOut), .EPCOut(EPCOut), .Req(Req),
    .o_dbg_state(o_dbg_state)
  );

  // ---- scoreboard ----
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_sr, m_cause, m_epc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_int();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic model_req();
    return model_int() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
  endfunction

  task automatic model_clear();
    m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
  endtask

  // ---- driver tasks ----
  task automatic idle_inputs();
    A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; WE = 1'b0; VPC = 32'd0;
    BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
  endtask

  // Inputs are already applied. Compare outputs at the falling edge,
  // compute the model's next state, then cross the rising edge.
  task automatic step();
    logic [31:0] n_sr, n_cause, n_epc;
    @(negedge clk);
    exp_q.push_back(model_read(A1));
    check("dout", DOut, exp_q.pop_front());
    check("req", {31'd0, Req}, {31'd0, model_req()});
    check("epcout", EPCOut, m_epc);
    check("state", {31'd0, o_dbg_state}, {31'd0, m_sr[1]});
    n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
    n_cause[15:10] = HWInt;
    if (model_req()) begin
      n_sr[1]       = 1'b1;
      n_cause[31]   = BDIn;
      n_cause[6:2]  = model_int() ? 5'd0 : ExcCodeIn;
      n_epc         = BDIn ? VPC - 32'd4 : VPC;
    end else begin
      if (WE && A2 == 5'd12) n_sr = DIn & SR_MASK;
      if (WE && A2 == 5'd14) n_epc = DIn;
      if (EXLClr) n_sr[1] = 1'b0;
    end
    @(posedge clk);
    m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
    #1;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    A1 = a;
    #1;
    check(tag, DOut, exp);
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---- stimulus ----
  initial begin
    logic [4:0] codes[5];
    codes = '{5'd4, 5'd5, 5'd8, 5'd10, 5'd12};

    idle_inputs();
    reset = 1'b0;
    model_clear();
    #2;
    // Reset state
    read_check("rst_sr", 5'd12, 32'd0);
    read_check("rst_cause", 5'd13, 32'd0);
    read_check("rst_epc", 5'd14, 32'd0);
    read_check("prid", 5'd15, PRID);
    read_check("unmapped", 5'd3, 32'd0);
    check("rst_req", {31'd0, Req}, 32'd0);
    apply_reset();

    // Ov capture, ExcCodeIn held afterwards
    ExcCodeIn = 5'd12; VPC = 32'h3010; BDIn = 1'b0; A1 = 5'd14;
    #1 check("ov_req_now", {31'd0, Req}, 32'd1);
    step();
    #1 check("ov_req_held", {31'd0, Req}, 32'd0);
    read_check("ov_epc", 5'd14, 32'h3010);
    read_check("ov_cause", 5'd13, 32'h0000_0030);
    read_check("ov_sr", 5'd12, 32'h0000_0002);
    step();
    ExcCodeIn = 5'd0; EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    read_check("eret_sr", 5'd12, 32'd0);

    // Delay-slot AdEL
    ExcCodeIn = 5'd4; VPC = 32'h3008; BDIn = 1'b1;
    step();
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    read_check("bd_epc", 5'd14, 32'h3004);
    read_check("bd_cause", 5'd13, 32'h8000_0010);
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;

    // Interrupt masking
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    step();
    WE = 1'b0; HWInt = 6'b000001; VPC = 32'h5000;
    #1 check("irq_req", {31'd0, Req}, 32'd1);
    step();
    read_check("irq_cause", 5'd13, 32'h0000_0400);
    HWInt = 6'b000010; EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    #1 check("masked_req", {31'd0, Req}, 32'd0);
    step();
    read_check("masked_ip", 5'd13, 32'h0000_0800);

    // Interrupt + RI + mtc0 EPC in the same cycle
    HWInt = 6'b000001; ExcCodeIn = 5'd10; WE = 1'b1; A2 = 5'd14;
    DIn = 32'h0000_FFFF; VPC = 32'h4000;
    step();
    ExcCodeIn = 5'd0; WE = 1'b0;
    read_check("simul_epc", 5'd14, 32'h4000);
    read_check("simul_cause", 5'd13, 32'h0000_0400);

    // eret with a pending enabled interrupt
    EXLClr = 1'b1;
    #1 check("eret_req_before", {31'd0, Req}, 32'd0);
    step();
    EXLClr = 1'b0;
    #1 check("eret_req_after", {31'd0, Req}, 32'd1);
    step();
    HWInt = 6'd0; EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;

    // Async reset in the middle of a handler
    ExcCodeIn = 5'd8; VPC = 32'h3000;
    step();
    ExcCodeIn = 5'd0;
    read_check("pre_rst_epc", 5'd14, 32'h3000);
    #2 reset = 1'b0;
    model_clear();
    #1 check("arst_req", {31'd0, Req}, 32'd0);
    check("arst_state", {31'd0, o_dbg_state}, 32'd0);
    check("arst_epcout", EPCOut, 32'd0);
    read_check("arst_sr", 5'd12, 32'd0);
    read_check("arst_cause", 5'd13, 32'd0);
    read_check("arst_epc", 5'd14, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      A1        = 5'($urandom_range(11, 16));
      case ($urandom_range(0, 4))
        0:       A2 = 5'd12;
        1:       A2 = 5'd13;
        2:       A2 = 5'd14;
        3:       A2 = 5'd15;
        default: A2 = 5'($urandom_range(0, 31));
      endcase
      WE        = ($urandom_range(0, 9) < 3);
      DIn       = $urandom();
      if ($urandom_range(0, 1) == 1) DIn[0] = 1'b1;
      VPC       = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      BDIn      = 1'($urandom_range(0, 1));
      ExcCodeIn = ($urandom_range(0, 9) < 2) ? codes[$urandom_range(0, 4)] : 5'd0;
      HWInt     = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
      EXLClr    = ($urandom_range(0, 9) < 2);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
